empaquetador_pixeles_mem: RTL and testbench

Packs processed pixels, delivered one per cycle by the filter datapath, into 32-bit memory words for the memory write side. Pixels are placed MSB to LSB (first pixel in bits 31:24). Up to four complete words are buffered for the memory writer, with ready/valid-style flags on both sides. A flush request commits a trailing partial word, zero-padded, at end of image.

---
 rtl/empaquetador_pixeles_mem_pkg.sv | 30 +++
 rtl/empaquetador_pixeles_mem_if.sv | 22 ++
 rtl/empaquetador_pixeles_mem_fifo_palabras_mem.sv | 49 ++++
 rtl/empaquetador_pixeles_mem.sv | 104 ++++++++++
 tb/tb_empaquetador_pixeles_mem.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/empaquetador_pixeles_mem_pkg.sv
// Shared constants and the pixel-insertion helper for the pixel packer.
package empaquetador_pixeles_mem_pkg;

    localparam int unsigned PIXEL_BITS         = 8;
    localparam int unsigned PIXELS_POR_PALABRA = 4;
    localparam int unsigned MEM_WORD_BITS      = PIXEL_BITS * PIXELS_POR_PALABRA;
    localparam int unsigned PROFUNDIDAD_FIFO   = 4;
    localparam int unsigned PTR_BITS           = 2;
    localparam int unsigned CNT_BITS           = 3;
    localparam int unsigned IDX_BITS           = 2;
    localparam int unsigned IDX_ULTIMO         = PIXELS_POR_PALABRA - 1;

    typedef logic [PIXEL_BITS-1:0]    pixel_t;
    typedef logic [MEM_WORD_BITS-1:0] palabra_t;

    typedef enum logic {
        EST_LIBRE = 1'b0,
        EST_PEND  = 1'b1
    } estado_t;

    // Place a pixel in its byte lane; slot 0 is the most significant byte.
    function automatic palabra_t insertar_pixel(input palabra_t palabra,
                                                input pixel_t   px,
                                                input logic [IDX_BITS-1:0] idx);
        int unsigned pos;
        pos = (IDX_ULTIMO - 32'(idx)) * PIXEL_BITS;
        return palabra | (MEM_WORD_BITS'(px) << pos);
    endfunction

endpackage

// File: rtl/empaquetador_pixeles_mem_if.sv
// Pixel-in / word-out bus between filter datapath, packer and memory writer.
interface empaquetador_pixeles_mem_if;
    import empaquetador_pixeles_mem_pkg::*;

    pixel_t   pixel;
    logic     write_pixel;
    logic     flush;
    logic     take_mem_data;
    palabra_t memory_data;
    logic     space_available;
    logic     data_available;

    modport master (
        output pixel, write_pixel, flush, take_mem_data,
        input  memory_data, space_available, data_available
    );

    modport slave (
        input  pixel, write_pixel, flush, take_mem_data,
        output memory_data, space_available, data_available
    );
endinterface

// File: rtl/empaquetador_pixeles_mem_fifo_palabras_mem.sv
// Four-entry word FIFO holding complete words for the memory writer.
module fifo_palabras_mem
    import empaquetador_pixeles_mem_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     push,
    input  palabra_t push_data,
    input  logic     pop,
    output palabra_t rd_data_c,
    output logic     full_c,
    output logic     empty_c
);

    palabra_t            mem [PROFUNDIDAD_FIFO];
    logic [PTR_BITS-1:0] wptr;
    logic [PTR_BITS-1:0] rptr;
    logic [CNT_BITS-1:0] cnt;

    // Storage, pointers and occupancy; push and pop are pre-qualified by the caller.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
            for (int i = 0; i < int'(PROFUNDIDAD_FIFO); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wptr] <= push_data;
                wptr      <= PTR_BITS'(wptr + 1'b1);
            end
            if (pop) begin
                rptr <= PTR_BITS'(rptr + 1'b1);
            end
            case ({push, pop})
                2'b10:   cnt <= CNT_BITS'(cnt + 1'b1);
                2'b01:   cnt <= CNT_BITS'(cnt - 1'b1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign rd_data_c = mem[rptr];
    assign full_c    = (cnt == CNT_BITS'(PROFUNDIDAD_FIFO));
    assign empty_c   = (cnt == '0);

endmodule

// File: rtl/empaquetador_pixeles_mem.sv
// Packs pixels MSB-first into 32-bit words, buffers them, and handles flush of a partial word.
module empaquetador_pixeles_mem
    import empaquetador_pixeles_mem_pkg::*;
(
    input  logic clk,
    input  logic reset,
    empaquetador_pixeles_mem_if.slave bus
);

    estado_t             estado;
    estado_t             estado_sig;
    palabra_t            asm_reg;
    palabra_t            asm_sig;
    logic [IDX_BITS-1:0] idx;
    logic [IDX_BITS-1:0] idx_sig;

    logic     push_c;
    palabra_t push_data_c;
    logic     pop_c;
    logic     full_c;
    logic     empty_c;
    logic     space_c;
    logic     wr_ok_c;
    palabra_t merged_c;

    // State, assembly register and byte index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado  <= EST_LIBRE;
            asm_reg <= '0;
            idx     <= '0;
        end else begin
            estado  <= estado_sig;
            asm_reg <= asm_sig;
            idx     <= idx_sig;
        end
    end

    // Pixel acceptance, word commit and flush sequencing.
    always_comb begin
        estado_sig  = estado;
        asm_sig     = asm_reg;
        idx_sig     = idx;
        push_c      = 1'b0;
        push_data_c = '0;
        space_c     = (estado == EST_LIBRE) && ((idx != IDX_BITS'(IDX_ULTIMO)) || !full_c);
        wr_ok_c     = bus.write_pixel && space_c;
        merged_c    = wr_ok_c ? insertar_pixel(asm_reg, bus.pixel, idx) : asm_reg;

        case (estado)
            EST_LIBRE: begin
                if (wr_ok_c && (idx == IDX_BITS'(IDX_ULTIMO))) begin
                    push_c      = 1'b1;
                    push_data_c = merged_c;
                    asm_sig     = '0;
                    idx_sig     = '0;
                end else begin
                    if (wr_ok_c) begin
                        asm_sig = merged_c;
                        idx_sig = IDX_BITS'(idx + 1'b1);
                    end
                    // A flush with nothing buffered and no write is a no-op.
                    if (bus.flush && (wr_ok_c || (idx != '0))) begin
                        if (!full_c) begin
                            push_c      = 1'b1;
                            push_data_c = merged_c;
                            asm_sig     = '0;
                            idx_sig     = '0;
                        end else begin
                            estado_sig = EST_PEND;
                        end
                    end
                end
            end
            EST_PEND: begin
                if (!full_c) begin
                    push_c      = 1'b1;
                    push_data_c = asm_reg;
                    asm_sig     = '0;
                    idx_sig     = '0;
                    estado_sig  = EST_LIBRE;
                end
            end
            default: estado_sig = EST_LIBRE;
        endcase
    end

    assign pop_c = bus.take_mem_data && !empty_c;

    fifo_palabras_mem u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_c),
        .push_data (push_data_c),
        .pop       (pop_c),
        .rd_data_c (bus.memory_data),
        .full_c    (full_c),
        .empty_c   (empty_c)
    );

    assign bus.space_available = space_c;
    assign bus.data_available  = !empty_c;

endmodule

// File: tb/tb_empaquetador_pixeles_mem.sv
// Scoreboard bench for the pixel packer: directed pixel streams, flushes, back-pressure and reset.
module tb_empaquetador_pixeles_mem;
    import empaquetador_pixeles_mem_pkg::*;

    logic clk;
    logic reset;

    empaquetador_pixeles_mem_if bus();

    empaquetador_pixeles_mem dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int       vectors;
    int       miscompares;
    palabra_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every consumed word is compared against the scoreboard head.
    always @(negedge clk) begin
        if (!reset && bus.data_available && bus.take_mem_data) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL word_pop: got %h expected none", bus.memory_data);
            end else begin
                palabra_t e;
                e = exp_q.pop_front();
                if (bus.memory_data !== e) begin
                    miscompares++;
                    $display("FAIL word_pop: got %h expected %h", bus.memory_data, e);
                end
            end
        end
    end

    // One clock of stimulus, applied from posedge+1 and released after the next edge.
    task automatic cyc(input logic wp, input logic [7:0] px, input logic fl, input logic tk);
        bus.write_pixel   = wp;
        bus.pixel         = px;
        bus.flush         = fl;
        bus.take_mem_data = tk;
        @(negedge clk);
        @(posedge clk);
        #1;
        bus.write_pixel   = 1'b0;
        bus.pixel         = '0;
        bus.flush         = 1'b0;
        bus.take_mem_data = 1'b0;
    endtask

    task automatic wr(input logic [7:0] px);
        cyc(1'b1, px, 1'b0, 1'b0);
    endtask

    task automatic drain(input int n, input string name);
        int k;
        k = 0;
        for (int i = 0; i < 16; i++) begin
            if (!bus.data_available) break;
            cyc(1'b0, 8'h00, 1'b0, 1'b1);
            k++;
        end
        check(name, 32'(k), 32'(n));
    endtask

    initial begin
        vectors           = 0;
        miscompares       = 0;
        reset             = 1'b1;
        bus.write_pixel   = 1'b0;
        bus.pixel         = '0;
        bus.flush         = 1'b0;
        bus.take_mem_data = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_memory_data", bus.memory_data, 32'h0);
        check("rst_data_available", 32'(bus.data_available), 32'h0);
        check("rst_space_available", 32'(bus.space_available), 32'h1);
        reset = 1'b0;

        // Single word and pop.
        exp_q.push_back(32'h11223344);
        wr(8'h11); wr(8'h22); wr(8'h33); wr(8'h44);
        check("t1_data_available", 32'(bus.data_available), 32'h1);
        check("t1_memory_data", bus.memory_data, 32'h11223344);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        check("t1_empty_after_take", 32'(bus.data_available), 32'h0);

        // Fill FIFO, back-pressure at the fourth byte, then resume.
        exp_q.push_back(32'h00010203);
        exp_q.push_back(32'h04050607);
        exp_q.push_back(32'h08090A0B);
        exp_q.push_back(32'h0C0D0E0F);
        exp_q.push_back(32'h10111213);
        for (int i = 0; i < 16; i++) wr(8'(i));
        check("t2_space_full_idx0", 32'(bus.space_available), 32'h1);
        wr(8'h10); wr(8'h11); wr(8'h12);
        check("t2_space_blocked", 32'(bus.space_available), 32'h0);
        wr(8'h13);
        check("t2_head_unchanged", bus.memory_data, 32'h00010203);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        check("t2_space_after_take", 32'(bus.space_available), 32'h1);
        wr(8'h13);
        drain(4, "t2_drain_count");

        // Flush of a partial word, no-op flush, and flush with same-cycle write.
        exp_q.push_back(32'hAABB0000);
        wr(8'hAA); wr(8'hBB);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("t3_flush_available", 32'(bus.data_available), 32'h1);
        check("t3_flush_word", bus.memory_data, 32'hAABB0000);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("t3_noop_flush", 32'(bus.data_available), 32'h0);
        check("t3_noop_space", 32'(bus.space_available), 32'h1);
        exp_q.push_back(32'h61620000);
        wr(8'h61);
        cyc(1'b1, 8'h62, 1'b1, 1'b0);
        check("t3_flush_with_write", bus.memory_data, 32'h61620000);
        drain(1, "t3_drain_count");

        // Flush while full stays pending until a pop frees a slot.
        exp_q.push_back(32'h20212223);
        exp_q.push_back(32'h24252627);
        exp_q.push_back(32'h28292A2B);
        exp_q.push_back(32'h2C2D2E2F);
        exp_q.push_back(32'hAABB0000);
        for (int i = 0; i < 16; i++) wr(8'(8'h20 + i));
        wr(8'hAA); wr(8'hBB);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("t4_space_pending", 32'(bus.space_available), 32'h0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        check("t4_space_still_pending", 32'(bus.space_available), 32'h0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        check("t4_space_released", 32'(bus.space_available), 32'h1);
        drain(4, "t4_drain_count");

        // Commit and pop in the same cycle at two words buffered.
        exp_q.push_back(32'h30313233);
        exp_q.push_back(32'h34353637);
        exp_q.push_back(32'h38393A3B);
        for (int i = 0; i < 11; i++) wr(8'(8'h30 + i));
        cyc(1'b1, 8'h3B, 1'b0, 1'b1);
        check("t5_head_after_concurrent", bus.memory_data, 32'h34353637);
        drain(2, "t5_drain_count");

        // Asynchronous reset mid-word discards everything.
        for (int i = 0; i < 14; i++) wr(8'(8'h40 + i));
        #2;
        reset = 1'b1;
        #1;
        check("t6_rst_memory_data", bus.memory_data, 32'h0);
        check("t6_rst_data_available", 32'(bus.data_available), 32'h0);
        check("t6_rst_space_available", 32'(bus.space_available), 32'h1);
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.push_back(32'h50515253);
        wr(8'h50); wr(8'h51); wr(8'h52); wr(8'h53);
        check("t6_fresh_word", bus.memory_data, 32'h50515253);
        drain(1, "t6_drain_count");

        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
